// File: rtl/arith_pkg.sv
// Shared arithmetic-stage definitions: bit-serial FSM states and the legal width range.
package arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: two cascaded half subtractors with their borrows ORed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1, w_b1, w_b2;

  // first half: a - b
  assign w_d1 = a ^ b;
  assign w_b1 = ~a & b;
  // second half: (a - b) - bin
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;

  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b, LSB first, one bit per clock; registered result with a done pulse.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be within 2..32");
    end
  endgenerate

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_r_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow, r_zero;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_bo, w_last;
  logic [WIDTH-1:0] w_res;

  full_subtractor u_fs (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .bin (r_br),
    .d   (w_d),
    .bout(w_bo)
  );

  assign w_last = (r_cnt == LAST);
  assign w_res  = {w_d, r_r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_br   <= 1'b0;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_r_sh <= w_res;
          r_br   <= w_bo;
          r_cnt  <= r_cnt + 1'b1;
          // outputs only change on the final bit, so they hold across later starts
          if (w_last) begin
            r_diff   <= w_res;
            r_borrow <= w_bo;
            r_zero   <= (w_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8 (directed), 4 and 16 (random, start held high).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8 = 0, s4 = 0, s16 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy8, done8, bo8, z8;
  logic        busy4, done4, bo4, z4;
  logic        busy16, done16, bo16, z16;
  logic [7:0]  diff8;
  logic [3:0]  diff4;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(bo8), .zero(z8));
  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(bo4), .zero(z4));
  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(bo16), .zero(z16));

  typedef struct {
    logic [31:0] d;
    logic        br;
    logic        z;
    int          acc;
  } exp_t;

  exp_t q8[$], q4[$], q16[$];
  exp_t m8, m4, m16;
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference: plain unsigned arithmetic, reduced mod 2^w
  function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y, int acc);
    exp_t e;
    bit [63:0] xx, yy, m;
    xx = 64'(x);
    yy = 64'(y);
    m  = (64'd1 << w) - 64'd1;
    e.d   = 32'((xx - yy) & m);
    e.br  = (xx < yy);
    e.z   = (e.d == 32'd0);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got done=1 expected done=0 (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) if (rst_n && done8) begin
    if (q8.size() == 0) unexpected("w8_unexpected_done");
    else begin
      m8 = q8.pop_front();
      chk("w8_diff", 32'(diff8), m8.d);
      chk("w8_borrow", 32'(bo8), 32'(m8.br));
      chk("w8_zero", 32'(z8), 32'(m8.z));
      chk("w8_latency", cyc - m8.acc, 8);
      chk("w8_busy_in_done", 32'(busy8), 1);
    end
  end

  always @(negedge clk) if (rst_n && done4) begin
    if (q4.size() == 0) unexpected("w4_unexpected_done");
    else begin
      m4 = q4.pop_front();
      chk("w4_diff", 32'(diff4), m4.d);
      chk("w4_borrow", 32'(bo4), 32'(m4.br));
      chk("w4_zero", 32'(z4), 32'(m4.z));
      chk("w4_latency", cyc - m4.acc, 4);
    end
  end

  always @(negedge clk) if (rst_n && done16) begin
    if (q16.size() == 0) unexpected("w16_unexpected_done");
    else begin
      m16 = q16.pop_front();
      chk("w16_diff", 32'(diff16), m16.d);
      chk("w16_borrow", 32'(bo16), 32'(m16.br));
      chk("w16_zero", 32'(z16), 32'(m16.z));
      chk("w16_latency", cyc - m16.acc, 16);
    end
  end

  task automatic issue8(logic [7:0] x, logic [7:0] y);
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 50) begin @(negedge clk); n++; end
    if (busy8) begin
      checks++; errors++;
      $display("FAIL w8_issue_timeout: got busy=1 expected busy=0");
    end
    s8 = 1; a8 = x; b8 = y;
    q8.push_back(model(8, 32'(x), 32'(y), cyc + 1));
    @(negedge clk);
    s8 = 0;
    chk("w8_busy_run", 32'(busy8), 1);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("w8_pending", q8.size(), 0);
    q8.delete();
    @(negedge clk);
  endtask

  task automatic rand4();
    int acc = 0, n = 0;
    while (acc < 500 && n < 20000) begin
      @(negedge clk); n++;
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1;
      if (!busy4) begin q4.push_back(model(4, 32'(a4), 32'(b4), cyc + 1)); acc++; end
    end
    @(negedge clk); s4 = 0;
    n = 0;
    while (q4.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("w4_accepted", acc, 500);
    chk("w4_pending", q4.size(), 0);
  endtask

  task automatic rand16();
    int acc = 0, n = 0;
    while (acc < 500 && n < 20000) begin
      @(negedge clk); n++;
      a16 = 16'($urandom); b16 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a16 = '0;
      if ($urandom_range(0, 7) == 0) b16 = 16'hFFFF;
      if ($urandom_range(0, 9) == 0) b16 = a16;
      s16 = 1;
      if (!busy16) begin q16.push_back(model(16, 32'(a16), 32'(b16), cyc + 1)); acc++; end
    end
    @(negedge clk); s16 = 0;
    n = 0;
    while (q16.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("w16_accepted", acc, 500);
    chk("w16_pending", q16.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_borrow", 32'(bo8), 0);
    chk("rst_zero", 32'(z8), 0);
    @(negedge clk); rst_n = 1;

    issue8(8'h05, 8'h03); drain8();
    repeat (3) @(negedge clk);
    chk("w8_hold_diff", 32'(diff8), 32'h02);

    issue8(8'h03, 8'h05);
    chk("w8_not_cleared_on_start", 32'(diff8), 32'h02);
    drain8();
    issue8(8'h00, 8'h01); drain8();
    issue8(8'hA7, 8'hA7); drain8();
    issue8(8'hFF, 8'h00); drain8();

    // extra start and operand churn while running must not disturb the result
    issue8(8'h40, 8'h15);
    repeat (2) @(negedge clk);
    s8 = 1; a8 = 8'h10; b8 = 8'h01;
    @(negedge clk); s8 = 0;
    repeat (4) begin a8 = 8'($urandom); b8 = 8'($urandom); @(negedge clk); end
    drain8();
    repeat (4) @(negedge clk);
    chk("w8_single_done", q8.size(), 0);

    // reset in the fourth RUN cycle aborts without a done pulse
    issue8(8'h9C, 8'h21);
    repeat (3) @(negedge clk);
    rst_n = 0;
    q8.delete();
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_diff", 32'(diff8), 0);
    chk("abort_borrow", 32'(bo8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    issue8(8'h9C, 8'h21); drain8();

    fork
      rand4();
      rand16();
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
